snake_tick_sequencer: RTL

Per-tick update controller for the snake game. On each `game_tick` pulse it runs the move sequence in a fixed order:
- compute the next head cell;
- check for a wall hit;
- scan the body RAM for a self-collision;
- decide eat/grow;
- commit the move to the body store;
- request a new apple and wait for it.

It sits between the tick divider, direction logic, snake body store and apple generator. It is the only block allowed to advance the snake or assert `game_over`.

---
 rtl/snake_tick_sequencer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/snake_tick_sequencer.sv
// Per-tick snake update sequencer: next head, wall check, body scan, commit, apple refill.
module snake_tick_sequencer #(
  parameter int unsigned GRID_W  = 40,
  parameter int unsigned GRID_H  = 30,
  parameter int unsigned MAX_LEN = 128,
  localparam int unsigned XW     = 6,
  localparam int unsigned YW     = 5,
  localparam int unsigned LW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          game_tick,
  input  logic [1:0]    dir,
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  input  logic [LW-1:0] length,
  input  logic [XW-1:0] apple_x,
  input  logic [YW-1:0] apple_y,
  output logic [LW-1:0] body_rd_addr,
  input  logic [XW-1:0] body_rd_x,
  input  logic [YW-1:0] body_rd_y,
  output logic          move_en,
  output logic          grow,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic          apple_req,
  input  logic          apple_done,
  output logic          busy,
  output logic          game_over,
  output logic          tick_overrun
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_SCAN   = 3'd2,
    S_COMMIT = 3'd3,
    S_APPLE  = 3'd4,
    S_OVER   = 3'd5
  } state_e;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  state_e        state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic [XW-1:0] hx_q, hx_d, ax_q, ax_d, nx_q, nx_d;
  logic [YW-1:0] hy_q, hy_d, ay_q, ay_d, ny_q, ny_d;
  logic [LW-1:0] len_q, len_d, n_q, n_d, j_q, j_d;
  logic          eat_q, eat_d;

  logic [LW-1:0] addr_q, addr_d;
  logic          move_en_q, move_en_d, grow_q, grow_d;
  logic [XW-1:0] next_x_q, next_x_d;
  logic [YW-1:0] next_y_q, next_y_d;
  logic          apple_req_q, apple_req_d, busy_q, busy_d;
  logic          game_over_q, game_over_d, tick_overrun_q, tick_overrun_d;

  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic          wall;
  logic          cand_eat;
  logic [LW-1:0] cand_n;
  logic          hit;

  // Candidate head cell and wall test from the latched snapshot
  always_comb begin
    cand_x = hx_q;
    cand_y = hy_q;
    wall   = 1'b0;
    unique case (dir_q)
      DIR_UP: begin
        cand_y = hy_q - YW'(1);
        wall   = (hy_q == '0);
      end
      DIR_DOWN: begin
        cand_y = hy_q + YW'(1);
        wall   = (hy_q == YW'(GRID_H - 1));
      end
      DIR_LEFT: begin
        cand_x = hx_q - XW'(1);
        wall   = (hx_q == '0);
      end
      default: begin
        cand_x = hx_q + XW'(1);
        wall   = (hx_q == XW'(GRID_W - 1));
      end
    endcase
    cand_eat = (cand_x == ax_q) && (cand_y == ay_q);
    // Tail cell is excluded from the scan when it vacates this tick
    cand_n   = cand_eat ? len_q : len_q - LW'(1);
    hit      = (body_rd_x == nx_q) && (body_rd_y == ny_q);
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    hx_d           = hx_q;
    hy_d           = hy_q;
    ax_d           = ax_q;
    ay_d           = ay_q;
    len_d          = len_q;
    nx_d           = nx_q;
    ny_d           = ny_q;
    eat_d          = eat_q;
    n_d            = n_q;
    j_d            = j_q;
    addr_d         = '0;
    move_en_d      = 1'b0;
    grow_d         = 1'b0;
    next_x_d       = '0;
    next_y_d       = '0;
    apple_req_d    = 1'b0;
    tick_overrun_d = tick_overrun_q;

    unique case (state_q)
      S_IDLE: begin
        if (game_tick) begin
          dir_d   = dir;
          hx_d    = head_x;
          hy_d    = head_y;
          ax_d    = apple_x;
          ay_d    = apple_y;
          len_d   = length;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (wall) begin
          state_d = S_OVER;
        end else begin
          nx_d  = cand_x;
          ny_d  = cand_y;
          eat_d = cand_eat;
          n_d   = cand_n;
          j_d   = '0;
          if (cand_n == '0) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_SCAN;
            addr_d  = (cand_n > LW'(1)) ? LW'(1) : '0;
          end
        end
      end
      S_SCAN: begin
        if (hit) begin
          state_d = S_OVER;
        end else if (j_q == n_q - LW'(1)) begin
          state_d = S_COMMIT;
        end else begin
          j_d    = j_q + LW'(1);
          // Only present addresses whose data will actually be compared
          addr_d = ((j_q + LW'(2)) < n_q) ? j_q + LW'(2) : '0;
        end
      end
      S_COMMIT: begin
        state_d = eat_q ? S_APPLE : S_IDLE;
      end
      S_APPLE: begin
        if (apple_done) state_d = S_IDLE;
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (game_tick && (state_q != S_IDLE) && (state_q != S_OVER)) tick_overrun_d = 1'b1;

    if (state_d == S_COMMIT) begin
      move_en_d = 1'b1;
      next_x_d  = nx_d;
      next_y_d  = ny_d;
      grow_d    = eat_d && (len_q < LW'(MAX_LEN));
    end
    apple_req_d = (state_q == S_COMMIT) && (state_d == S_APPLE);
    busy_d      = (state_d != S_IDLE) && (state_d != S_OVER);
    game_over_d = (state_d == S_OVER);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      dir_q          <= '0;
      hx_q           <= '0;
      hy_q           <= '0;
      ax_q           <= '0;
      ay_q           <= '0;
      len_q          <= '0;
      nx_q           <= '0;
      ny_q           <= '0;
      eat_q          <= 1'b0;
      n_q            <= '0;
      j_q            <= '0;
      addr_q         <= '0;
      move_en_q      <= 1'b0;
      grow_q         <= 1'b0;
      next_x_q       <= '0;
      next_y_q       <= '0;
      apple_req_q    <= 1'b0;
      busy_q         <= 1'b0;
      game_over_q    <= 1'b0;
      tick_overrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      hx_q           <= hx_d;
      hy_q           <= hy_d;
      ax_q           <= ax_d;
      ay_q           <= ay_d;
      len_q          <= len_d;
      nx_q           <= nx_d;
      ny_q           <= ny_d;
      eat_q          <= eat_d;
      n_q            <= n_d;
      j_q            <= j_d;
      addr_q         <= addr_d;
      move_en_q      <= move_en_d;
      grow_q         <= grow_d;
      next_x_q       <= next_x_d;
      next_y_q       <= next_y_d;
      apple_req_q    <= apple_req_d;
      busy_q         <= busy_d;
      game_over_q    <= game_over_d;
      tick_overrun_q <= tick_overrun_d;
    end
  end

  assign body_rd_addr = addr_q;
  assign move_en      = move_en_q;
  assign grow         = grow_q;
  assign next_x       = next_x_q;
  assign next_y       = next_y_q;
  assign apple_req    = apple_req_q;
  assign busy         = busy_q;
  assign game_over    = game_over_q;
  assign tick_overrun = tick_overrun_q;

endmodule
